vga_pixel_serializer: RTL

VGA_PIXEL_SERIALIZER -- requirements
Module: vga_pixel_serializer

---
 rtl/vga_pixel_serializer.sv | 116 +++++++++++
 1 files changed

// File: rtl/vga_pixel_serializer.sv
// Pixel FIFO plus a 2x-clock half-word serializer feeding a VGA DAC, with syncs delayed to match vga_out.
// Optional test pattern generator enabled by defining VGA_PIXEL_SER_TESTPAT_EN (adds the test_en input).
module vga_pixel_serializer #(
    parameter int                  DATA_W     = 24,
    parameter int                  FIFO_DEPTH = 8,
    parameter logic [DATA_W/2-1:0] BLANK_VAL  = '0
) (
    input  logic                            pixel_clk_2x,
    input  logic                            reset,
    input  logic                            hsync,
    input  logic                            vsync,
    input  logic                            de,
    input  logic                            pix_valid,
    input  logic [DATA_W-1:0]               pix_data,
`ifdef VGA_PIXEL_SER_TESTPAT_EN
    input  logic                            test_en,
`endif
    output logic                            pix_ready,
    output logic [DATA_W/2-1:0]             vga_out,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            de_out,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int HW = DATA_W / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              phase, hsync_q, low_pend;
    logic [HW-1:0]     low_data;
    logic [DATA_W-1:0] rd_word;
    logic              full, empty, push, pop, slot, starve, hsync_rise;
    logic              pat_on;
    logic [HW-1:0]     pat_word;

`ifdef VGA_PIXEL_SER_TESTPAT_EN
    logic [10:0] x;

    assign pat_on   = test_en;
    assign pat_word = x[3] ? '1 : '0;

    always_ff @(posedge pixel_clk_2x) begin
        if (reset)           x <= '0;
        else if (hsync_rise) x <= '0;
        else if (slot)       x <= x + 11'd1;
    end
`else
    assign pat_on   = 1'b0;
    assign pat_word = '0;
`endif

    assign full       = (level == LW'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign pix_ready  = ~full;
    assign fifo_level = level;
    assign hsync_rise = hsync & ~hsync_q;
    assign rd_word    = mem[rd_ptr];
    // A pending low beat blocks the next slot so a popped pair always completes.
    assign slot       = ~phase & de & ~low_pend;
    assign push       = pix_valid & ~full;
    assign pop        = slot & ~empty & ~pat_on;
    assign starve     = slot & empty & ~pat_on;

    always_ff @(posedge pixel_clk_2x) begin
        if (push) mem[wr_ptr] <= pix_data;
    end

    always_ff @(posedge pixel_clk_2x) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            phase     <= 1'b0;
            hsync_q   <= 1'b0;
            low_pend  <= 1'b0;
            low_data  <= BLANK_VAL;
            vga_out   <= BLANK_VAL;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            de_out    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            phase     <= hsync_rise ? 1'b0 : ~phase;
            hsync_q   <= hsync;
            hsync_out <= hsync;
            vsync_out <= vsync;
            de_out    <= de;
            underflow <= starve;
            if (low_pend) begin
                vga_out  <= low_data;
                low_pend <= 1'b0;
            end else if (pop) begin
                vga_out  <= rd_word[DATA_W-1:HW];
                low_data <= rd_word[HW-1:0];
                low_pend <= 1'b1;
            end else if (slot && pat_on) begin
                vga_out  <= pat_word;
                low_data <= pat_word;
                low_pend <= 1'b1;
            end else begin
                vga_out  <= BLANK_VAL;
            end
        end
    end
endmodule
